// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the video timing generator.
package video_timing_pkg;

  // Coordinate fields in the delay-line payload are carried at this fixed width.
  localparam int unsigned CoordW = 16;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned total_of(input int unsigned disp, input int unsigned fp,
                                           input int unsigned pulse, input int unsigned bp);
    return disp + fp + pulse + bp;
  endfunction

  // Sync bits are carried active-high and given their polarity only at the pins.
  typedef struct packed {
    logic              act;
    logic              hs;
    logic              vs;
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
    logic              fs;
    logic              ls;
  } vt_payload_t;

  localparam vt_payload_t PayloadIdle = '0;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line with synchronous reset to a constant value.
module pipe_delay #(
  parameter type         T       = logic,
  parameter int unsigned DEPTH   = 1,
  parameter T            RST_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  T     din,
  output T     dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = clk ^ rst;
    assign dout = din;
  end else begin : g_shift
    T stage [DEPTH];

    // Shift one stage per clock; reset flushes every stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= din;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised video timing generator with a read request issued LEAD cycles early.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned HDISP  = 800,
  parameter int unsigned VDISP  = 480,
  parameter int unsigned HFP    = 40,
  parameter int unsigned HPULSE = 48,
  parameter int unsigned HBP    = 40,
  parameter int unsigned VFP    = 13,
  parameter int unsigned VPULSE = 3,
  parameter int unsigned VBP    = 29,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0,
  parameter int unsigned LEAD   = 2
) (
  input  logic                         pixel_clk,
  input  logic                         pixel_rst,
  input  logic                         enable,
  output logic                         rd_req,
  output logic                         HS,
  output logic                         VS,
  output logic                         BLANK,
  output logic [width_of(HDISP)-1:0]   x,
  output logic [width_of(VDISP)-1:0]   y,
  output logic                         frame_start,
  output logic                         line_start
);

  localparam int unsigned HTOTAL = total_of(HDISP, HFP, HPULSE, HBP);
  localparam int unsigned VTOTAL = total_of(VDISP, VFP, VPULSE, VBP);
  localparam int unsigned HW     = width_of(HTOTAL);
  localparam int unsigned VW     = width_of(VTOTAL);
  localparam int unsigned XW     = width_of(HDISP);
  localparam int unsigned YW     = width_of(VDISP);

  if (HDISP == 0 || VDISP == 0 || HPULSE == 0 || LEAD > 15 ||
      XW > CoordW || YW > CoordW) begin : g_bad_params
    $error("video_timing_gen: illegal parameter set");
  end

  logic [HW-1:0] hcnt_q;
  logic [VW-1:0] vcnt_q;
  logic          frame_en_q;
  logic          h_last, v_last;
  logic [31:0]   h, v;

  assign h_last = (hcnt_q == HW'(HTOTAL - 1));
  assign v_last = (vcnt_q == VW'(VTOTAL - 1));
  // Compare in 32 bits so porch sums equal to the total never truncate.
  assign h      = 32'(hcnt_q);
  assign v      = 32'(vcnt_q);

  // Raster counters; enable is only taken at the last pixel of a frame.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      frame_en_q <= 1'b0;
    end else if (h_last) begin
      hcnt_q <= '0;
      vcnt_q <= v_last ? '0 : vcnt_q + 1'b1;
      if (v_last) frame_en_q <= enable;
    end else begin
      hcnt_q <= hcnt_q + 1'b1;
    end
  end

  vt_payload_t s0_d, s0_q, out_p;

  // Decode the current raster position into the stage-0 payload.
  always_comb begin
    s0_d     = PayloadIdle;
    s0_d.act = (h < HDISP) && (v < VDISP) && frame_en_q;
    s0_d.hs  = (h >= HDISP + HFP) && (h < HDISP + HFP + HPULSE);
    s0_d.vs  = (v >= VDISP + VFP) && (v < VDISP + VFP + VPULSE);
    s0_d.x   = s0_d.act ? CoordW'(hcnt_q) : '0;
    s0_d.y   = s0_d.act ? CoordW'(vcnt_q) : '0;
    s0_d.fs  = s0_d.act && (h == 0) && (v == 0);
    s0_d.ls  = s0_d.act && (h == 0);
  end

  // Stage-0 register; its act bit is the read request itself.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) s0_q <= PayloadIdle;
    else           s0_q <= s0_d;
  end

  pipe_delay #(
    .T       (vt_payload_t),
    .DEPTH   (LEAD),
    .RST_VAL (PayloadIdle)
  ) u_delay (
    .clk  (pixel_clk),
    .rst  (pixel_rst),
    .din  (s0_q),
    .dout (out_p)
  );

  assign rd_req      = s0_q.act;
  assign BLANK       = out_p.act;
  assign HS          = out_p.hs ? HS_POL : ~HS_POL;
  assign VS          = out_p.vs ? VS_POL : ~VS_POL;
  assign x           = out_p.x[XW-1:0];
  assign y           = out_p.y[YW-1:0];
  assign frame_start = out_p.fs;
  assign line_start  = out_p.ls;

  logic unused_coord;
  assign unused_coord = ^{out_p.x, out_p.y};

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: random enable timing against an arithmetic raster model.
module tb_video_timing_gen;

  localparam int HD = 160, VD = 90, HF = 8, HP = 16, HB = 24, VF = 2, VP = 3, VB = 5, LD = 2;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       rd_req, hs, vs, blank, fs, ls;
  logic [7:0] x;
  logic [6:0] y;

  always #5 clk = ~clk;

  video_timing_gen #(
    .HDISP (HD), .VDISP (VD), .HFP (HF), .HPULSE (HP), .HBP (HB),
    .VFP (VF), .VPULSE (VP), .VBP (VB), .HS_POL (1'b0), .VS_POL (1'b0), .LEAD (LD)
  ) dut (
    .pixel_clk   (clk),
    .pixel_rst   (rst),
    .enable      (en),
    .rd_req      (rd_req),
    .HS          (hs),
    .VS          (vs),
    .BLANK       (blank),
    .x           (x),
    .y           (y),
    .frame_start (fs),
    .line_start  (ls)
  );

  typedef struct {int n; int x; int y;} req_t;

  int   checks = 0;
  int   failures = 0;
  int   n = 0;
  bit   fen [0:7];
  int   req_cnt [0:7];
  int   vs_low [0:7];
  req_t sb [$];
  int   fs_seen [$];
  int   last_ls = -1;
  int   hs_fall_n = -1;
  logic hs_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at n=%0d", tag, obs, exp, n);
    end
  endtask

  // {HS, VS, BLANK, x[7:0], y[6:0], fs, ls} for raster position q since reset release.
  function automatic logic [19:0] model_video(input int q);
    int h, v, f;
    bit a, hsa, vsa;
    if (q < 0) return {1'b1, 1'b1, 18'd0};
    h   = q % HT;
    v   = (q / HT) % VT;
    f   = q / FR;
    a   = (h < HD) && (v < VD) && fen[f];
    hsa = (h >= HD + HF) && (h < HD + HF + HP);
    vsa = (v >= VD + VF) && (v < VD + VF + VP);
    return {~hsa, ~vsa, a, a ? 8'(h) : 8'd0, a ? 7'(v) : 7'd0, a && h == 0 && v == 0, a && h == 0};
  endfunction

  task automatic step();
    logic [19:0] mv, mreq;
    req_t r;
    bit rst_edge;
    @(posedge clk);
    rst_edge = rst;
    if (rst) begin
      n = 0;
      for (int i = 0; i < 8; i++) fen[i] = 1'b0;
      sb.delete();
      last_ls = -1;
      hs_fall_n = -1;
      hs_prev = 1'b1;
    end else begin
      if (n % FR == FR - 1) fen[n / FR + 1] = en;
      n++;
    end
    #1;
    if (rst_edge) begin
      check("rst_rd_req", 32'(rd_req), 32'd0);
      check("rst_video", 32'({hs, vs, blank, x, y, fs, ls}), 32'({1'b1, 1'b1, 18'd0}));
    end else begin
      mreq = model_video(n - 1);
      mv   = model_video(n - 1 - LD);
      check("rd_req", 32'(rd_req), 32'(mreq[17]));
      check("video", 32'({hs, vs, blank, x, y, fs, ls}), 32'(mv));
      if (rd_req) begin
        req_cnt[(n - 1) / FR]++;
        sb.push_back('{n, int'(mreq[16:9]), int'(mreq[8:2])});
      end
      if (blank) begin
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          r = sb.pop_front();
          check("sb_latency", 32'(n - r.n), 32'(LD));
          check("sb_x", 32'(x), 32'(r.x));
          check("sb_y", 32'(y), 32'(r.y));
        end
      end
      if (n - 1 - LD >= 0 && !vs) vs_low[(n - 1 - LD) / FR]++;
      if (fs) fs_seen.push_back(n);
      if (ls) last_ls = n;
      if (hs_prev && !hs) begin
        hs_fall_n = n;
        if (last_ls >= 0 && n - last_ls < HT) check("hs_after_ls", 32'(n - last_ls), 32'(HD + HF));
      end
      if (!hs_prev && hs && hs_fall_n >= 0) check("hs_width", 32'(n - hs_fall_n), 32'(HP));
      hs_prev = hs;
    end
  endtask

  initial begin
    int drop_at, raise_at;
    for (int i = 0; i < 8; i++) begin
      req_cnt[i] = 0;
      vs_low[i]  = 0;
      fen[i]     = 1'b0;
    end
    drop_at  = FR + 2000 + int'($urandom_range(0, 15000));
    raise_at = 2 * FR + 2000 + int'($urandom_range(0, 15000));

    // Reset held ~130 ns with enable already high.
    rst = 1'b1;
    en  = 1'b1;
    repeat (13) step();
    rst = 1'b0;

    // Frame 0 blanked, frame 1 active, enable dropped somewhere in frame 1.
    while (n < drop_at) step();
    en = 1'b0;
    // Frame 2 disabled, enable restored somewhere in it, frame 3 active.
    while (n < raise_at) step();
    en = 1'b1;
    while (n < 3 * FR + 40 * HT + 50) step();

    check("req_frame0", 32'(req_cnt[0]), 32'd0);
    check("req_frame1", 32'(req_cnt[1]), 32'(HD * VD));
    check("req_frame2", 32'(req_cnt[2]), 32'd0);
    check("vs_low_frame1", 32'(vs_low[1]), 32'(VP * HT));
    check("vs_low_frame2", 32'(vs_low[2]), 32'(VP * HT));
    check("fs_count", 32'(fs_seen.size()), 32'd2);
    if (fs_seen.size() >= 2) begin
      check("fs_first", 32'(fs_seen[0]), 32'(FR + LD + 1));
      check("fs_gap", 32'(fs_seen[1] - fs_seen[0]), 32'(2 * FR));
    end

    // Mid-frame reset with the counters at hcnt=50, vcnt=40.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2 * HT + 20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
